// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives a 1-cycle-latency instruction memory and
// presents {pc, instr} to decode through a 2-entry buffer. Optional macro: FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 30
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_clken,
  input  logic [31:0]       imem_q,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_busy
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              if_misalign
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam int ENTRY_W = 65;
  localparam logic [31:0] NOP = 32'h0000_0013;
`else
  localparam int ENTRY_W = 64;
`endif

  state_t              state, state_nxt;
  logic [31:0]         pc, inflight_pc, redir_target;
  logic                inflight, kill, halt;
  logic [1:0]          count;
  logic [2:0]          occupancy;
  logic                pop, push, issue;
  logic [ENTRY_W-1:0]  entry [2];
  logic [ENTRY_W-1:0]  push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_pend, halted, redir_mis;

  assign redir_mis    = |redirect_pc[1:0];
  assign redir_target = redirect_pc;
  assign halt         = halted;
  // A pending trap owns the empty buffer the cycle after the redirect; no read can be in flight then.
  assign push         = (inflight & ~kill) | trap_pend;
  assign push_entry   = trap_pend ? {1'b1, pc, NOP} : {1'b0, inflight_pc, imem_q};
  assign if_misalign  = entry[0][64];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trap_pend <= 1'b0;
      halted    <= 1'b0;
    end else begin
      trap_pend <= redirect_valid & redir_mis;
      if (redirect_valid) halted <= redir_mis;
    end
  end
`else
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;
  assign halt         = 1'b0;
  assign push         = inflight & ~kill;
  assign push_entry   = {inflight_pc, imem_q};
`endif

  assign pop        = if_valid & id_ready;
  assign occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == RUN) & fetch_en & ~redirect_valid & ~halt & (occupancy < 3'd2);
  assign imem_clken = issue;
  assign imem_addr  = pc[ADDR_W+1:2];
  assign if_valid   = (count != 2'd0);
  assign if_pc      = entry[0][63:32];
  assign if_instr   = entry[0][31:0];
  assign fetch_busy = inflight | (count != 2'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_en)  state_nxt = RUN;
      RUN:     if (!fetch_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue stage: PC advance and one-cycle memory read tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      kill     <= redirect_valid & inflight;
      if (issue) inflight_pc <= pc;
      if (redirect_valid) pc <= redir_target;
      else if (issue)     pc <= pc + 32'd4;
    end
  end

  // Return stage: entry[0] is the head; a redirect flushes whatever arrives this cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      for (int i = 0; i < 2; i++) entry[i] <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry[0] <= push_entry;
          else               entry[1] <= push_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry[0] <= entry[1];
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry[0] <= push_entry;
          end else begin
            entry[0] <= entry[1];
            entry[1] <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && count == 2'd2));

endmodule
